// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared parameters and state encoding for the HUB75 frame bank scheduler
//
// Purpose: default geometry of the double-buffered frame memory and the
//          scheduler state encoding, shared by the interface, tracker and top.
// Ports:   none (package).
package hub75_pkg;

    localparam int ADDR_W_DEF      = 8;    // per-bank word address width
    localparam int FRAME_WORDS_DEF = 192;  // 64-bit words per frame
    localparam int OVR_W_DEF       = 8;    // saturating overrun counter width

    typedef enum logic {
        FILL  = 1'b0,   // back bank is being written, nothing waiting
        READY = 1'b1    // a complete frame waits for the scanner's frame end
    } sched_state_e;

endpackage

// File: rtl/frame_bank_scheduler_if.sv
// rtl/frame_bank_scheduler_if.sv - loader/scanner/BRAM signal bundle for the frame bank scheduler
//
// Purpose: groups the SPI loader write side, the panel scanner read side,
//          the control bit and the scheduler status outputs.
// Ports:   slave modport  - scheduler view (loader/scanner inputs, BRAM/status outputs)
//          master modport - environment view (drives inputs, observes outputs)
interface frame_bank_scheduler_if #(
    parameter int ADDR_W = hub75_pkg::ADDR_W_DEF,
    parameter int OVR_W  = hub75_pkg::OVR_W_DEF
);
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic              wr_abort_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_frame_end_i;
    logic              freeze_i;
    logic              wr_en_o;
    logic [ADDR_W:0]   wr_addr_o;
    logic [ADDR_W:0]   rd_addr_o;
    logic              rd_bank_o;
    logic              swap_pending_o;
    logic              swap_o;
    logic              seq_err_o;
    logic [OVR_W-1:0]  ovr_cnt_o;

    modport slave (
        input  wr_en_i, wr_addr_i, wr_abort_i, rd_addr_i, rd_frame_end_i, freeze_i,
        output wr_en_o, wr_addr_o, rd_addr_o, rd_bank_o, swap_pending_o, swap_o,
               seq_err_o, ovr_cnt_o
    );

    modport master (
        output wr_en_i, wr_addr_i, wr_abort_i, rd_addr_i, rd_frame_end_i, freeze_i,
        input  wr_en_o, wr_addr_o, rd_addr_o, rd_bank_o, swap_pending_o, swap_o,
               seq_err_o, ovr_cnt_o
    );

endinterface

// File: rtl/frame_bank_scheduler_tracker.sv
// rtl/frame_bank_scheduler_tracker.sv - word sequence tracker for the back-bank frame fill
//
// Purpose: follows the loader's word addresses, detects a complete in-order
//          frame and keeps the sticky sequence error flag.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          wr_acc_i        - a write is accepted this cycle
//          wr_addr_i       - word address of that write
//          cnt_clr_i       - bank flip: restart the word count
//          err_clr_i       - loader resync: restart count and clear the error
//          frame_done_o    - combinational pulse on the completing write
//          seq_err_o       - sticky missing/out-of-order word flag
module frame_write_tracker #(
    parameter int ADDR_W      = hub75_pkg::ADDR_W_DEF,
    parameter int FRAME_WORDS = hub75_pkg::FRAME_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_acc_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              cnt_clr_i,
    input  logic              err_clr_i,
    output logic              frame_done_o,
    output logic              seq_err_o
);
    // One extra bit so cnt can hold addr+1 for any address without wrapping.
    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] WORDS = CNT_W'(FRAME_WORDS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;   // no sequence error since the last address-0 write
    logic             err_q, err_d;
    logic [CNT_W-1:0] addr_ext;

    assign addr_ext = {1'b0, wr_addr_i};

    always_comb begin
        cnt_d        = cnt_q;
        clean_d      = clean_q;
        err_d        = err_q;
        frame_done_o = 1'b0;
        if (err_clr_i) begin
            cnt_d   = '0;
            clean_d = 1'b1;
            err_d   = 1'b0;
        end else if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (wr_acc_i) begin
            if (wr_addr_i == '0) begin
                // Address 0 always starts a fresh frame, whatever came before.
                cnt_d   = CNT_W'(1);
                clean_d = 1'b1;
            end else if (addr_ext < WORDS && addr_ext == cnt_q) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                // Gap, reorder or out-of-bank address: resync just past it.
                cnt_d   = addr_ext + 1'b1;
                clean_d = 1'b0;
                err_d   = 1'b1;
            end
            frame_done_o = (addr_ext == LAST) && (cnt_q == LAST) && clean_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            clean_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            err_q   <= err_d;
        end
    end

    assign seq_err_o = err_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// rtl/frame_bank_scheduler.sv - double-buffer bank scheduler between SPI loader, HUB75 scanner and BRAM
//
// Purpose: loader writes the back bank, scanner reads the front bank; a fully
//          written frame is swapped in only at the scanner's frame end.
// Ports:   clk, rst - clk_20M, synchronous active-high reset
//          bus      - frame_bank_scheduler_if.slave (loader, scanner, control,
//                     BRAM address outputs and status)
module frame_bank_scheduler
    import hub75_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int OVR_W       = OVR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_bank_scheduler_if.slave bus
);
    sched_state_e     state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic             pend_q, pend_d;
    logic             flip_q, flip_d;
    logic             swap_q, swap_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             wr_acc;
    logic             frame_done;

    assign wr_acc = bus.wr_en_i & ~bus.wr_abort_i & ~rst;

    frame_write_tracker #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .wr_acc_i     (wr_acc),
        .wr_addr_i    (bus.wr_addr_i),
        .cnt_clr_i    (flip_d),
        .err_clr_i    (bus.wr_abort_i),
        .frame_done_o (frame_done),
        .seq_err_o    (bus.seq_err_o)
    );

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        flip_d    = 1'b0;
        swap_d    = flip_q;   // swap_o trails the registered flip by one cycle
        if (bus.wr_abort_i) begin
            state_d = FILL;
            pend_d  = 1'b0;
        end else if (state_q == FILL) begin
            // Frame end is ignored here, including one coinciding with completion.
            if (frame_done) begin
                state_d = READY;
                pend_d  = 1'b1;
            end
        end else begin
            if (wr_acc) begin
                // New data overwrites the pending frame; it beats a same-cycle frame end.
                if (ovr_q != '1) begin
                    ovr_d = ovr_q + 1'b1;
                end
                state_d = frame_done ? READY : FILL;
                pend_d  = frame_done;
            end else if (bus.rd_frame_end_i && !bus.freeze_i) begin
                flip_d    = 1'b1;
                rd_bank_d = ~rd_bank_q;
                state_d   = FILL;
                pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            rd_bank_q <= 1'b0;
            pend_q    <= 1'b0;
            flip_q    <= 1'b0;
            swap_q    <= 1'b0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            pend_q    <= pend_d;
            flip_q    <= flip_d;
            swap_q    <= swap_d;
            ovr_q     <= ovr_d;
        end
    end

    // Write bank is always the complement of the front bank.
    assign bus.wr_en_o        = wr_acc;
    assign bus.wr_addr_o      = {~rd_bank_q, bus.wr_addr_i};
    assign bus.rd_addr_o      = {rd_bank_q, bus.rd_addr_i};
    assign bus.rd_bank_o      = rd_bank_q;
    assign bus.swap_pending_o = pend_q;
    assign bus.swap_o         = swap_q;
    assign bus.ovr_cnt_o      = ovr_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb/tb_frame_bank_scheduler.sv - directed scoreboard bench for frame_bank_scheduler
module tb_frame_bank_scheduler;
    import hub75_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   exp_ovr = 0;
    bit   exp_bank_q[$];

    always #5 clk = ~clk;

    frame_bank_scheduler_if dif ();

    frame_bank_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Swap scoreboard: every flip the bench provokes pushes the bank it must show.
    always @(negedge clk) begin
        if (!rst && dif.swap_o !== 1'b0) begin
            if (exp_bank_q.size() == 0) begin
                chk("swap_unexpected", 32'(dif.swap_o), 32'd0);
            end else begin
                chk("swap_bank", 32'(dif.rd_bank_o), 32'(exp_bank_q.pop_front()));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input int a);
        dif.wr_en_i   = 1'b1;
        dif.wr_addr_i = 8'(a);
        cyc();
        dif.wr_en_i   = 1'b0;
    endtask

    task automatic frame();
        for (int a = 0; a < FRAME_WORDS_DEF; a++) wr(a);
    endtask

    task automatic fend();
        dif.rd_frame_end_i = 1'b1;
        cyc();
        dif.rd_frame_end_i = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        dif.wr_en_i        = 1'b0;
        dif.wr_addr_i      = '0;
        dif.wr_abort_i     = 1'b0;
        dif.rd_addr_i      = 8'd5;
        dif.rd_frame_end_i = 1'b0;
        dif.freeze_i       = 1'b0;
        idle(2);

        // 1: reset state, first frame and flip
        dif.wr_en_i = 1'b1;
        #1;
        chk("rst_wr_en_gated", 32'(dif.wr_en_o), 32'd0);
        dif.wr_en_i = 1'b0;
        chk("rst_rd_bank", 32'(dif.rd_bank_o), 32'd0);
        chk("rst_wr_bank", 32'(dif.wr_addr_o[8]), 32'd1);
        chk("rst_pending", 32'(dif.swap_pending_o), 32'd0);
        chk("rst_swap", 32'(dif.swap_o), 32'd0);
        chk("rst_seq_err", 32'(dif.seq_err_o), 32'd0);
        chk("rst_ovr", 32'(dif.ovr_cnt_o), 32'd0);
        rst = 1'b0;
        cyc();
        dif.wr_en_i = 1'b1;
        dif.wr_addr_i = 8'd7;
        #1;
        chk("wr_en_pass", 32'(dif.wr_en_o), 32'd1);
        chk("wr_addr_o", 32'(dif.wr_addr_o), 32'h107);
        dif.wr_en_i = 1'b0;
        frame();
        chk("t1_pending", 32'(dif.swap_pending_o), 32'd1);
        chk("t1_rd_addr_pre", 32'(dif.rd_addr_o), 32'h005);
        exp_bank_q.push_back(1'b1);
        fend();
        chk("t1_rd_addr_flip", 32'(dif.rd_addr_o), 32'h105);
        chk("t1_wr_bank_flip", 32'(dif.wr_addr_o[8]), 32'd0);
        chk("t1_pending_clr", 32'(dif.swap_pending_o), 32'd0);
        chk("t1_swap_early", 32'(dif.swap_o), 32'd0);
        cyc();
        chk("t1_swap_pulse", 32'(dif.swap_o), 32'd1);
        cyc();
        chk("t1_swap_end", 32'(dif.swap_o), 32'd0);

        // 2: skipped word, then loader resync
        for (int a = 0; a < FRAME_WORDS_DEF; a++) if (a != 100) wr(a);
        chk("t2_seq_err", 32'(dif.seq_err_o), 32'd1);
        chk("t2_no_ready", 32'(dif.swap_pending_o), 32'd0);
        fend();
        idle(3);
        chk("t2_no_flip", 32'(dif.rd_bank_o), 32'd1);
        dif.wr_en_i    = 1'b1;
        dif.wr_abort_i = 1'b1;
        #1;
        chk("t2_abort_gate", 32'(dif.wr_en_o), 32'd0);
        cyc();
        dif.wr_en_i    = 1'b0;
        dif.wr_abort_i = 1'b0;
        chk("t2_err_clr", 32'(dif.seq_err_o), 32'd0);
        chk("t2_bank_kept", 32'(dif.rd_bank_o), 32'd1);

        // 3: overrun of a pending frame, refill, flip
        frame();
        chk("t3_pending", 32'(dif.swap_pending_o), 32'd1);
        wr(0);
        exp_ovr = 1;
        chk("t3_ovr", 32'(dif.ovr_cnt_o), 32'(exp_ovr));
        chk("t3_pending_cancel", 32'(dif.swap_pending_o), 32'd0);
        chk("t3_no_err", 32'(dif.seq_err_o), 32'd0);
        frame();
        chk("t3_refill_pending", 32'(dif.swap_pending_o), 32'd1);
        exp_bank_q.push_back(1'b0);
        fend();
        chk("t3_flip", 32'(dif.rd_bank_o), 32'd0);
        idle(3);

        // 4: completion coinciding with frame end does not flip
        for (int a = 0; a < FRAME_WORDS_DEF - 1; a++) wr(a);
        dif.rd_frame_end_i = 1'b1;
        wr(FRAME_WORDS_DEF - 1);
        dif.rd_frame_end_i = 1'b0;
        chk("t4_pending", 32'(dif.swap_pending_o), 32'd1);
        idle(3);
        chk("t4_no_flip", 32'(dif.rd_bank_o), 32'd0);
        exp_bank_q.push_back(1'b1);
        fend();
        chk("t4_flip", 32'(dif.rd_bank_o), 32'd1);
        idle(3);

        // 5: freeze withholds the swap
        frame();
        dif.freeze_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fend();
            idle(2);
        end
        chk("t5_frozen_bank", 32'(dif.rd_bank_o), 32'd1);
        chk("t5_frozen_pending", 32'(dif.swap_pending_o), 32'd1);
        dif.freeze_i = 1'b0;
        exp_bank_q.push_back(1'b0);
        fend();
        chk("t5_flip", 32'(dif.rd_bank_o), 32'd0);
        idle(3);

        // 6: overrun counter saturation, then reset while READY
        for (int i = 0; i < 258; i++) begin
            wr(0);
            if (i > 0) begin
                exp_ovr = (exp_ovr == 255) ? 255 : exp_ovr + 1;
                chk("t6_ovr", 32'(dif.ovr_cnt_o), 32'(exp_ovr));
            end
            for (int a = 1; a < FRAME_WORDS_DEF; a++) wr(a);
        end
        chk("t6_ovr_sat", 32'(dif.ovr_cnt_o), 32'd255);
        exp_bank_q.push_back(1'b1);
        fend();
        chk("t6_flip", 32'(dif.rd_bank_o), 32'd1);
        idle(3);
        frame();
        wr(5);
        chk("t6_err_set", 32'(dif.seq_err_o), 32'd1);
        frame();
        chk("t6_pending", 32'(dif.swap_pending_o), 32'd1);
        rst = 1'b1;
        cyc();
        chk("t6_rst_bank", 32'(dif.rd_bank_o), 32'd0);
        chk("t6_rst_wr_bank", 32'(dif.wr_addr_o[8]), 32'd1);
        chk("t6_rst_pending", 32'(dif.swap_pending_o), 32'd0);
        chk("t6_rst_ovr", 32'(dif.ovr_cnt_o), 32'd0);
        chk("t6_rst_err", 32'(dif.seq_err_o), 32'd0);
        chk("t6_rst_swap", 32'(dif.swap_o), 32'd0);
        rst = 1'b0;
        idle(3);
        chk("swap_missing", 32'(exp_bank_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
